// File: rtl/multi_sync_pkg.sv
// Shared limits and helpers for the multi-channel synchroniser/glitch filter.
// Latency: n/a (declarations only); backpressure: none.
package multi_sync_pkg;

  localparam int WIDTH_MIN    = 1;
  localparam int WIDTH_MAX    = 32;
  localparam int STAGES_MIN   = 2;
  localparam int STAGES_MAX   = 4;
  localparam int FILT_LEN_MIN = 1;
  localparam int FILT_LEN_MAX = 255;

  // Counter must hold values 0..FILT_LEN-1; sized with one value of headroom.
  function automatic int cnt_width(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchroniser, agreement counter, registered level and pulses.
// Latency: STAGES+FILT_LEN edges from a stable input change; no backpressure (free-running).
module sync_filter_chan
  import multi_sync_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_LEN = 3,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam int            CW       = cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [STAGES-1:0] chain_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sync_q, sync_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              glitch_q, glitch_d;
  logic              d;

  assign d = chain_q[STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    sync_d   = sync_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    if (d == sync_q) begin
      cnt_d    = '0;
      glitch_d = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      // FILT_LEN-th consecutive disagreeing cycle: commit the new level.
      sync_d = d;
      cnt_d  = '0;
      rise_d = d;
      fall_d = ~d;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q  <= {STAGES{INIT_BIT}};
      cnt_q    <= '0;
      sync_q   <= INIT_BIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      chain_q  <= {chain_q[STAGES-2:0], sig_i};
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign sync_o   = sync_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: rtl/multi_sync_filter.sv
// WIDTH independent async inputs, each synchronised and glitch-filtered with edge/glitch pulses.
// Latency: STAGES+FILT_LEN edges; no backpressure, outputs are free-running registered levels/pulses.
module multi_sync_filter
  import multi_sync_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               FILT_LEN = 3,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "multi_sync_filter: WIDTH out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "multi_sync_filter: STAGES out of range");
  end
  if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
    $fatal(1, "multi_sync_filter: FILT_LEN out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES   (STAGES),
      .FILT_LEN (FILT_LEN),
      .INIT_BIT (INIT[i])
    ) u_chan (
      .clk_i    (clk_100M),
      .rst_i    (rst),
      .sig_i    (sig[i]),
      .sync_o   (sig_sync[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .glitch_o (glitch[i])
    );
  end

endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed + random bench for multi_sync_filter: default instance and a STAGES=3/FILT_LEN=1 instance
// share inputs and are checked every cycle against a window-based reference model.
module tb_multi_sync_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;

  logic [3:0] a_sync, a_rise, a_fall, a_glitch;
  logic [3:0] b_sync, b_rise, b_fall, b_glitch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_sync_filter #(.WIDTH(4), .STAGES(2), .FILT_LEN(3), .INIT(4'b0000)) u_dflt (
    .clk_100M (clk),
    .rst      (rst),
    .sig      (sig),
    .sig_sync (a_sync),
    .rise     (a_rise),
    .fall     (a_fall),
    .glitch   (a_glitch)
  );

  multi_sync_filter #(.WIDTH(4), .STAGES(3), .FILT_LEN(1), .INIT(4'b0000)) u_fast (
    .clk_100M (clk),
    .rst      (rst),
    .sig      (sig),
    .sig_sync (b_sync),
    .rise     (b_rise),
    .fall     (b_fall),
    .glitch   (b_glitch)
  );

  // Reference model: a delay line of input samples, then a window of the last
  // synchronised samples; a level is committed once FILT_LEN consecutive
  // samples all disagree with the current output.
  logic [3:0] dl [2][8];
  logic [3:0] wl [2][8];
  int         wcnt [2];
  logic [3:0] m_sync [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic [3:0] m_glitch [2];

  logic [3:0] sh [5];
  bit         dly_en = 1'b0;

  task automatic model_update(input int m, input int stg, input int fl);
    logic [3:0] d;
    logic [3:0] prev;
    logic       pv;
    logic       old;
    logic       take;
    if (rst) begin
      for (int k = 0; k < 8; k++) dl[m][k] = 4'b0000;
      wcnt[m]     = 0;
      m_sync[m]   = 4'b0000;
      m_rise[m]   = 4'b0000;
      m_fall[m]   = 4'b0000;
      m_glitch[m] = 4'b0000;
    end else begin
      d = dl[m][stg-1];
      for (int k = 7; k > 0; k--) dl[m][k] = dl[m][k-1];
      dl[m][0] = sig;
      prev = wl[m][0];
      pv   = (wcnt[m] > 0);
      for (int k = 7; k > 0; k--) wl[m][k] = wl[m][k-1];
      wl[m][0] = d;
      if (wcnt[m] < 8) wcnt[m]++;
      for (int c = 0; c < 4; c++) begin
        old  = m_sync[m][c];
        take = (wcnt[m] >= fl);
        for (int k = 0; k < fl; k++) if (wl[m][k][c] == old) take = 1'b0;
        m_rise[m][c]   = take && d[c];
        m_fall[m][c]   = take && !d[c];
        m_glitch[m][c] = (d[c] == old) && pv && (prev[c] != old);
        if (take) m_sync[m][c] = d[c];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update(0, 2, 3);
    model_update(1, 3, 1);
    for (int k = 4; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = sig;
    @(negedge clk);
    chk("dflt_sync",   {28'd0, a_sync},   {28'd0, m_sync[0]});
    chk("dflt_rise",   {28'd0, a_rise},   {28'd0, m_rise[0]});
    chk("dflt_fall",   {28'd0, a_fall},   {28'd0, m_fall[0]});
    chk("dflt_glitch", {28'd0, a_glitch}, {28'd0, m_glitch[0]});
    chk("dflt_excl",   {28'd0, (a_rise & a_fall) | (a_rise & a_glitch) | (a_fall & a_glitch)}, 32'd0);
    chk("fast_sync",   {28'd0, b_sync},   {28'd0, m_sync[1]});
    chk("fast_rise",   {28'd0, b_rise},   {28'd0, m_rise[1]});
    chk("fast_fall",   {28'd0, b_fall},   {28'd0, m_fall[1]});
    chk("fast_glitch", {28'd0, b_glitch}, {28'd0, m_glitch[1]});
    if (dly_en) begin
      chk("fast_delay", {28'd0, b_sync}, {28'd0, sh[3]});
      chk("fast_edges", {28'd0, b_rise | b_fall}, {28'd0, sh[3] ^ sh[4]});
    end
  endtask

  initial begin
    int g1, e1, hi1, rstep, fstep, hi2, nr2;
    for (int m = 0; m < 2; m++) begin
      wcnt[m] = 0;
      for (int k = 0; k < 8; k++) begin
        dl[m][k] = 4'b0000;
        wl[m][k] = 4'b0000;
      end
    end
    for (int k = 0; k < 5; k++) sh[k] = 4'b0000;

    // Reset state
    rst = 1'b1;
    sig = 4'b0000;
    repeat (3) step();
    chk("rst_sync",  {28'd0, a_sync}, 32'd0);
    chk("rst_pulse", {28'd0, a_rise | a_fall | a_glitch}, 32'd0);
    chk("rst_fast",  {28'd0, b_sync | b_rise | b_fall | b_glitch}, 32'd0);

    // Single rising change on channel 0: 5-cycle latency, one-cycle pulse
    rst = 1'b0;
    step();
    sig = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 4) chk("lat_sync_early", {31'd0, a_sync[0]}, 32'd0);
      if (i == 5) begin
        chk("lat_sync", {31'd0, a_sync[0]}, 32'd1);
        chk("lat_rise", {31'd0, a_rise[0]}, 32'd1);
      end
      if (i == 6) chk("lat_rise_end", {31'd0, a_rise[0]}, 32'd0);
    end

    // Two-cycle pulse on channel 1 is rejected with one glitch pulse
    g1 = 0; e1 = 0; hi1 = 0;
    sig = 4'b0011;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) sig = 4'b0001;
      step();
      g1  += int'(a_glitch[1]);
      e1  += int'(a_rise[1]) + int'(a_fall[1]);
      hi1 += int'(a_sync[1]);
    end
    chk("short_glitch", g1, 32'd1);
    chk("short_edges", e1, 32'd0);
    chk("short_sync", hi1, 32'd0);

    // Three-cycle pulse on channel 2 passes exactly
    rstep = -1; fstep = -1; hi2 = 0; nr2 = 0;
    sig = 4'b0101;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) sig = 4'b0001;
      step();
      if (a_rise[2]) begin rstep = i; nr2++; end
      if (a_fall[2]) fstep = i;
      hi2 += int'(a_sync[2]);
    end
    chk("exact_rise_at", rstep, 32'd5);
    chk("exact_fall_at", fstep, 32'd8);
    chk("exact_high", hi2, 32'd3);
    chk("exact_nrise", nr2, 32'd1);

    // All channels toggle together, mixed directions
    sig = 4'b1110;
    repeat (5) step();
    chk("multi_rise", {28'd0, a_rise}, 32'hE);
    chk("multi_fall", {28'd0, a_fall}, 32'h1);

    // Reset while a change on channel 3 is pending
    sig = 4'b0000;
    repeat (8) step();
    sig = 4'b1000;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_sync", {31'd0, a_sync[3]}, 32'd0);
    chk("rstmid_pulse", {31'd0, a_rise[3] | a_fall[3] | a_glitch[3]}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i < 5) chk("rstmid_wait", {31'd0, a_sync[3] | a_rise[3] | a_glitch[3]}, 32'd0);
    end
    chk("rstmid_sync_back", {31'd0, a_sync[3]}, 32'd1);
    chk("rstmid_rise_back", {31'd0, a_rise[3]}, 32'd1);

    // Random traffic; changes are sparse enough for the default instance to pass some
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) sig = 4'($urandom_range(0, 15));
      step();
      if (i == 5) dly_en = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
